// File: rtl/line_echo_ctrl.sv
// Line echo controller: counts complete lines arriving into an external
// show-ahead FIFO and, after an idle gap, enables the transmitter and pops
// words out one per done_tx handshake.
module line_echo_ctrl #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] TERM_CHAR      = 8'h0A,
    parameter int                    WAIT_CYCLES    = 11,
    parameter int                    LINE_CNT_WIDTH = 4,
    parameter int                    MODE           = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      done_rx,
    input  logic [DATA_WIDTH-1:0]     data_rx,
    input  logic                      empty,
    input  logic [DATA_WIDTH-1:0]     fifo_dout,
    input  logic                      done_tx,
    output logic                      en_tx,
    output logic                      rd_en_fifo,
    output logic [LINE_CNT_WIDTH-1:0] lines_pending,
    output logic                      line_ovf
);

    localparam int            CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SEND, LAST} state_t;

    state_t                    state, state_nx;
    logic [CW-1:0]             wait_cnt, cnt_nx;
    logic                      first_pop;
    logic                      rx_term, pop_term;
    logic [LINE_CNT_WIDTH-1:0] lines_nx;
    logic                      ovf_nx;

    assign rx_term    = done_rx & (data_rx == TERM_CHAR);
    // First SEND cycle pops without a done_tx to prime the transmitter.
    assign rd_en_fifo = (state == SEND) & ~empty & (first_pop | done_tx);
    assign pop_term   = rd_en_fifo & (fifo_dout == TERM_CHAR);

    // Saturating line counter update; a simultaneous push and pop cancel.
    always_comb begin
        lines_nx = lines_pending;
        ovf_nx   = line_ovf;
        if (rx_term & ~pop_term) begin
            if (lines_pending == '1) ovf_nx = 1'b1;
            else                     lines_nx = lines_pending + 1'b1;
        end else if (pop_term & ~rx_term & (lines_pending != '0)) begin
            lines_nx = lines_pending - 1'b1;
        end
    end

    // Next-state and wait counter.
    always_comb begin
        state_nx = state;
        cnt_nx   = wait_cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (~empty && ((MODE != 0) || (lines_pending != '0))) state_nx = WAIT;
            end
            WAIT: begin
                if (empty) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = SEND;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = wait_cnt + 1'b1;
                end
            end
            SEND: begin
                // Last terminator of the backlog popped, or nothing left to pop.
                if ((MODE == 0) && pop_term && (lines_nx == '0)) state_nx = LAST;
                else if (empty)                                   state_nx = LAST;
            end
            LAST: begin
                if (done_tx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, counters and registered transmitter enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            en_tx         <= 1'b0;
            first_pop     <= 1'b1;
            lines_pending <= '0;
            line_ovf      <= 1'b0;
        end else begin
            state         <= state_nx;
            wait_cnt      <= cnt_nx;
            en_tx         <= (state_nx == SEND) || (state_nx == LAST);
            first_pop     <= (state != SEND);
            lines_pending <= lines_nx;
            line_ovf      <= ovf_nx;
        end
    end

endmodule
